vscpu_prog_loader: RTL and testbench

Boot-time program loader between a byte-stream source (UART receiver or testbench) and the VerySimpleCPU RAM port. After reset it holds the CPU in reset and assembles incoming bytes into 32-bit words, writing them to RAM from address 0 upward. When loading completes it releases the CPU and becomes a zero-latency pass-through for the CPU's RAM write/address signals. RAM read data goes directly from RAM to the CPU; this block does not route it.

---
 rtl/vscpu_pkg.sv | 22 ++
 rtl/vscpu_prog_loader.sv | 177 +++++++++++++++++
 tb/tb_vscpu_prog_loader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vscpu_pkg.sv
// Shared VerySimpleCPU constants and program-loader state encoding.
// Defining VSCPU_LOADER_CKSUM_EN adds the CKSUM state to the encoding.
package vscpu_pkg;

    localparam int DATA_W         = 32;
    localparam int ADDR_W         = 14;
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        LD_HDR_HI = 3'd0,
        LD_HDR_LO = 3'd1,
        LD_BYTE   = 3'd2,
        LD_WRITE  = 3'd3,
`ifdef VSCPU_LOADER_CKSUM_EN
        LD_CKSUM  = 3'd4,
`endif
        LD_RUN    = 3'd5,
        LD_ERR    = 3'd6
    } loader_state_e;

endpackage

// File: rtl/vscpu_prog_loader.sv
// Boot loader: byte stream -> RAM words, then CPU release and RAM pass-through.
// VSCPU_LOADER_CKSUM_EN: expect a trailing mod-256 sum byte of all data bytes.
module vscpu_prog_loader #(
    parameter int ADDR_W = vscpu_pkg::ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        rx_valid,
    input  logic [7:0]                  rx_data,
    output logic                        rx_ready,
    input  logic                        cpu_wrEn,
    input  logic [ADDR_W-1:0]           cpu_addr,
    input  logic [vscpu_pkg::DATA_W-1:0] cpu_data,
    output logic                        ram_wrEn,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic [vscpu_pkg::DATA_W-1:0] ram_data,
    output logic                        cpu_rst,
    output logic                        done,
    output logic                        err
);
    import vscpu_pkg::*;

    loader_state_e       state_q, state_d;
    logic [7:0]          hi_q, hi_d;
    logic [15:0]         n_q, n_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic                cpu_rst_q, done_q, err_q;
`ifdef VSCPU_LOADER_CKSUM_EN
    logic [7:0]          sum_q, sum_d;
`endif

    logic [15:0] n_hdr;
    logic        too_big;
    logic        last_word;

    assign n_hdr     = {hi_q, rx_data};
    assign too_big   = 64'(n_hdr) > (64'd1 << ADDR_W);
    assign last_word = 32'(idx_q) == (32'(n_q) - 32'd1);

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        n_d      = n_q;
        idx_d    = idx_q;
        bcnt_d   = bcnt_q;
        word_d   = word_q;
`ifdef VSCPU_LOADER_CKSUM_EN
        sum_d    = sum_q;
`endif
        rx_ready = 1'b0;
        ram_wrEn = 1'b0;
        ram_addr = '0;
        ram_data = '0;
        unique case (state_q)
            LD_HDR_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    hi_d    = rx_data;
                    state_d = LD_HDR_LO;
                end
            end
            LD_HDR_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    n_d    = n_hdr;
                    idx_d  = '0;
                    bcnt_d = '0;
`ifdef VSCPU_LOADER_CKSUM_EN
                    sum_d  = '0;
`endif
                    if (n_hdr == 16'd0) begin
`ifdef VSCPU_LOADER_CKSUM_EN
                        state_d = LD_CKSUM;
`else
                        state_d = LD_RUN;
`endif
                    end else if (too_big) begin
                        state_d = LD_ERR;
                    end else begin
                        state_d = LD_BYTE;
                    end
                end
            end
            LD_BYTE: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    word_d = {word_q[DATA_W-9:0], rx_data};
                    bcnt_d = bcnt_q + 2'd1;
`ifdef VSCPU_LOADER_CKSUM_EN
                    sum_d  = sum_q + rx_data;
`endif
                    if (bcnt_q == 2'(BYTES_PER_WORD - 1)) begin
                        state_d = LD_WRITE;
                    end
                end
            end
            LD_WRITE: begin
                ram_wrEn = 1'b1;
                ram_addr = idx_q;
                ram_data = word_q;
                if (last_word) begin
`ifdef VSCPU_LOADER_CKSUM_EN
                    state_d = LD_CKSUM;
`else
                    state_d = LD_RUN;
`endif
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = LD_BYTE;
                end
            end
`ifdef VSCPU_LOADER_CKSUM_EN
            LD_CKSUM: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    state_d = (rx_data == sum_q) ? LD_RUN : LD_ERR;
                end
            end
`endif
            LD_RUN: begin
                ram_wrEn = cpu_wrEn;
                ram_addr = cpu_addr;
                ram_data = cpu_data;
                if (start) state_d = LD_HDR_HI;
            end
            LD_ERR: begin
                if (start) state_d = LD_HDR_HI;
            end
            default: state_d = LD_HDR_HI;
        endcase
        // Reset silences the stream and RAM port in the same cycle
        if (rst) begin
            rx_ready = 1'b0;
            ram_wrEn = 1'b0;
            ram_addr = '0;
            ram_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LD_HDR_HI;
            hi_q      <= '0;
            n_q       <= '0;
            idx_q     <= '0;
            bcnt_q    <= '0;
            word_q    <= '0;
`ifdef VSCPU_LOADER_CKSUM_EN
            sum_q     <= '0;
`endif
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            bcnt_q    <= bcnt_d;
            word_q    <= word_d;
`ifdef VSCPU_LOADER_CKSUM_EN
            sum_q     <= sum_d;
`endif
            cpu_rst_q <= (state_d != LD_RUN);
            done_q    <= (state_d == LD_RUN);
            err_q     <= (state_d == LD_ERR);
        end
    end

    assign cpu_rst = cpu_rst_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_vscpu_prog_loader.sv
// Scoreboard bench for vscpu_prog_loader; honours VSCPU_LOADER_CKSUM_EN.
// Expected RAM writes are queued from word lists; a monitor pops them.
module tb_vscpu_prog_loader;
    import vscpu_pkg::*;

`ifdef VSCPU_LOADER_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready;
    logic              cpu_wrEn = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [31:0]       cpu_data = '0;
    logic              ram_wrEn;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_data;
    logic              cpu_rst;
    logic              done;
    logic              err;

    vscpu_prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .cpu_wrEn(cpu_wrEn), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .ram_wrEn(ram_wrEn), .ram_addr(ram_addr), .ram_data(ram_data),
        .cpu_rst(cpu_rst), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rise_cnt = 0;
    logic done_prev = 1'b0;
    logic [ADDR_W+31:0] exp_q[$];
    logic [31:0] wq[$];

    // Scoreboard monitor: every load-phase RAM write must match the queue head
    always @(negedge clk) begin
        if (!rst && ram_wrEn && !done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0h data=%08h, expected none",
                         ram_addr, ram_data);
            end else begin
                logic [ADDR_W+31:0] e;
                e = exp_q.pop_front();
                if ({ram_addr, ram_data} !== e) begin
                    errors++;
                    $display("FAIL ram_write: got addr=%0h data=%08h, expected addr=%0h data=%08h",
                             ram_addr, ram_data, e[ADDR_W+31:32], e[31:0]);
                end
            end
        end
        if (done && !done_prev) rise_cnt = rise_cnt + 1;
        done_prev <= done;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps && $urandom_range(0, 2) == 0) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        #1;
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        checks++;
        if (!rx_ready) begin
            errors++;
            $display("FAIL handshake: got rx_ready=0 for 50 cycles, expected 1");
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("start_cpu_rst", cpu_rst, 1);
        chk("start_done", done, 0);
        chk("start_err", err, 0);
    endtask

    // Reference: stream = N (big-endian), words big-endian, optional sum byte
    task automatic load(input bit gaps, input bit bad_ck);
        logic [7:0] s[$];
        logic [7:0] sum;
        logic [15:0] n;
        int r0;
        bit ok;
        sum = 8'h00;
        n = 16'(wq.size());
        s.push_back(n[15:8]);
        s.push_back(n[7:0]);
        for (int i = 0; i < wq.size(); i++) begin
            logic [31:0] w;
            w = wq[i];
            for (int k = 3; k >= 0; k--) begin
                s.push_back(w[k*8 +: 8]);
                sum = sum + w[k*8 +: 8];
            end
            exp_q.push_back({ADDR_W'(i), w});
        end
        if (CK) s.push_back(bad_ck ? sum + 8'h01 : sum);
        ok = !bad_ck;
        r0 = rise_cnt;
        for (int i = 0; i < s.size(); i++) send_byte(s[i], gaps);
        #1;
        if (n != 0 && !CK) begin
            chk("last_write_en", ram_wrEn, 1);
            chk("last_write_addr", ram_addr, ADDR_W'(n - 1));
            chk("done_before_run", done, 0);
            chk("cpu_rst_before_run", cpu_rst, 1);
            @(negedge clk);
            #1;
        end
        chk("load_done", done, ok);
        chk("load_err", err, !ok);
        chk("load_cpu_rst", cpu_rst, !ok);
        chk("load_releases", rise_cnt - r0, ok);
        chk("load_queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_ram_wrEn", ram_wrEn, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("first_ready", rx_ready, 1);

        wq = {32'hDEADBEEF, 32'h00000001};
        load(1'b0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            logic [ADDR_W-1:0] a;
            logic [31:0] d;
            logic we;
            @(negedge clk);
            we = 1'($urandom);
            a = ADDR_W'($urandom);
            d = $urandom;
            cpu_wrEn = we;
            cpu_addr = a;
            cpu_data = d;
            #1;
            chk("pt_wrEn", ram_wrEn, we);
            chk("pt_addr", ram_addr, a);
            chk("pt_data", ram_data, d);
        end
        cpu_wrEn = 1'b0;

        start_pulse();
        wq.delete();
        load(1'b0, 1'b0);

        start_pulse();
        send_byte(8'h40, 1'b0);
        send_byte(8'h01, 1'b0);
        rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("hdr_big_err", err, 1);
        chk("hdr_big_ready", rx_ready, 0);
        chk("hdr_big_cpu_rst", cpu_rst, 1);
        chk("hdr_big_done", done, 0);
        rx_valid = 1'b0;
        start_pulse();
        chk("err_restart_ready", rx_ready, 1);
        wq = {32'hDEADBEEF, 32'h00000001};
        load(1'b0, 1'b0);

        start_pulse();
        load(1'b1, 1'b0);

        start_pulse();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        send_byte(8'hBE, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        load(1'b1, 1'b0);

        for (int it = 0; it < 6; it++) begin
            int n;
            start_pulse();
            n = $urandom_range(1, 5);
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            load(1'($urandom), 1'b0);
        end

`ifdef VSCPU_LOADER_CKSUM_EN
        start_pulse();
        wq = {32'h01020304};
        load(1'b0, 1'b0);
        start_pulse();
        load(1'b0, 1'b1);
        start_pulse();
        load(1'b1, 1'b0);
`endif

        chk("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
